// File: rtl/cas_recorder_if.sv
// Tape-side inputs and record-buffer outputs of the cassette recorder.
// master drives the tape bits and reads the buffer port; slave is the recorder.
interface cas_recorder_if #(
    parameter int AW = 17
);
    logic          ce;
    logic          motor;
    logic [1:0]    level;
    logic          rec_we;
    logic [AW-1:0] rec_addr;
    logic [7:0]    rec_data;
    logic [AW-1:0] rec_len;
    logic          active;
    logic          overflow;

    modport master (
        output ce, motor, level,
        input  rec_we, rec_addr, rec_data, rec_len, active, overflow
    );

    modport slave (
        input  ce, motor, level,
        output rec_we, rec_addr, rec_data, rec_len, active, overflow
    );
endinterface

// File: rtl/cas_recorder.sv
// Decodes the Level II cassette pulse train from the port $FF tape bits into bytes
// and writes them as a .CAS image into a host-readable buffer.
module cas_recorder #(
    parameter int          AW        = 17,
    parameter logic [11:0] DATA_MAX  = 12'hA80,
    parameter logic [15:0] TIMEOUT   = 16'h2000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input logic           clock,
    input logic           reset,
    cas_recorder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [1:0]    prev_level;
    logic [15:0]   gap;
    logic          cell_open;
    logic          seen1;
    logic [7:0]    sr;
    logic [2:0]    bitcnt;
    logic          rec_we_q;
    logic [7:0]    rec_data_q;
    logic [AW-1:0] rec_addr_q;
    logic [AW-1:0] rec_len_q;
    logic          overflow_q;

    logic          pulse;
    logic          data_pulse;
    logic          clk_pulse;
    logic          timeout;
    logic          emit;
    logic [7:0]    sr_next;
    logic          tape_on;
    logic          sync_hit;
    logic          byte_done;
    logic          wr_fire;

    // A cell closes either at the next clock pulse or at timeout; both emit seen1.
    always_comb begin
        pulse      = (bus.level != 2'b00) && (prev_level == 2'b00);
        data_pulse = pulse && cell_open && (gap < {4'h0, DATA_MAX});
        clk_pulse  = pulse && !data_pulse;
        timeout    = !pulse && cell_open && (gap == TIMEOUT - 16'd1);
        emit       = (clk_pulse && cell_open) || timeout;
        sr_next    = {sr[6:0], seen1};
        tape_on    = bus.ce && bus.motor && (state != IDLE);
        sync_hit   = tape_on && emit && (state == HUNT) && (sr_next == SYNC_BYTE);
        byte_done  = tape_on && emit && (state == DATA) && (bitcnt == 3'd7);
        wr_fire    = (sync_hit || byte_done) && !overflow_q;

        state_d = state;
        if (bus.ce) begin
            if (!bus.motor) begin
                state_d = IDLE;
            end else begin
                case (state)
                    IDLE:    state_d = HUNT;
                    HUNT:    if (sync_hit) state_d = DATA;
                    DATA:    if (timeout) state_d = HUNT;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            prev_level <= 2'b00;
            gap        <= 16'd0;
            cell_open  <= 1'b0;
            seen1      <= 1'b0;
            sr         <= 8'd0;
            bitcnt     <= 3'd0;
            rec_we_q   <= 1'b0;
            rec_data_q <= 8'd0;
            rec_addr_q <= '0;
            rec_len_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state    <= state_d;
            rec_we_q <= wr_fire;
            if (wr_fire) begin
                rec_data_q <= sync_hit ? SYNC_BYTE : sr_next;
            end

            // Address advances the clock after the strobe; the last slot never wraps.
            if (rec_we_q) begin
                if (rec_addr_q == {AW{1'b1}}) begin
                    overflow_q <= 1'b1;
                end else begin
                    rec_addr_q <= rec_addr_q + AW'(1);
                end
                if (rec_len_q != {AW{1'b1}}) begin
                    rec_len_q <= rec_len_q + AW'(1);
                end
            end

            if (bus.ce) begin
                prev_level <= bus.level;
                if (clk_pulse) begin
                    gap <= 16'd0;
                end else if (gap != 16'hFFFF) begin
                    gap <= gap + 16'd1;
                end

                if (!bus.motor || state == IDLE) begin
                    cell_open <= 1'b0;
                    seen1     <= 1'b0;
                    bitcnt    <= 3'd0;
                    if (bus.motor) begin
                        sr         <= 8'd0;
                        rec_addr_q <= '0;
                        rec_len_q  <= '0;
                        overflow_q <= 1'b0;
                    end
                end else begin
                    if (data_pulse) begin
                        seen1 <= 1'b1;
                    end
                    if (clk_pulse) begin
                        cell_open <= 1'b1;
                        seen1     <= 1'b0;
                    end
                    if (timeout) begin
                        cell_open <= 1'b0;
                        seen1     <= 1'b0;
                    end
                    if (emit) begin
                        sr <= sr_next;
                        if (state == DATA) begin
                            bitcnt <= timeout ? 3'd0 : bitcnt + 3'd1;
                        end else if (sync_hit) begin
                            bitcnt <= 3'd0;
                        end
                    end
                end
            end
        end
    end

    assign bus.rec_we   = rec_we_q;
    assign bus.rec_data = rec_data_q;
    assign bus.rec_addr = rec_addr_q;
    assign bus.rec_len  = rec_len_q;
    assign bus.active   = (state == DATA);
    assign bus.overflow = overflow_q;

endmodule
